line_stream_feeder: RTL and testbench
=====================================

Name: line_stream_feeder

Overview:
- Synthesizable frame feeder that drives a line-buffered image filter (e.g. imageProcessTop) over its valid/ready pixel stream.
- Pulls pixels from an upstream source (memory reader/DMA) and issues them in the filter's required line order: a prime burst of PRIME_LINES lines, then one line per filter interrupt, then PAD_LINES lines of PAD_VALUE.
- Counts filter output beats and signals frame completion.
- Generalises the sequence previously hard-coded for 512x512 8-bit frames to parametrised size, pixel width, prime depth and padding, and adds backpressure support and interrupt credit tracking.

Parameters:
- IMG_WIDTH, 512, pixels per line (>=2).
- IMG_HEIGHT, 512, lines per frame (>=PRIME_LINES).
- PIX_W, 8, pixel width in bits.
- PRIME_LINES, 4, lines sent after start without waiting for an interrupt (>=1).
- PAD_LINES, 2, trailing lines of PAD_VALUE, each gated by one interrupt (0 allowed).
- PAD_VALUE, 0, value of padding pixels (PIX_W bits).
- CREDIT_W, 4, width of the interrupt credit counter.

Ports:
- axi_clk, in, 1, clock; all logic on the rising edge.
- axi_reset_n, in, 1, asynchronous active-low reset.
- i_start, in, 1, one-cycle start pulse; ignored while o_busy=1.
- i_src_valid, in, 1, source pixel valid.
- i_src_data, in, PIX_W, source pixel.
- o_src_ready, out, 1, feeder accepts the source pixel this cycle.
- o_data_valid, out, 1, pixel valid toward the filter.
- o_data, out, PIX_W, pixel toward the filter.
- i_data_ready, in, 1, filter accepts the pixel.
- i_intr, in, 1, filter interrupt (line buffer freed); level or pulse.
- i_res_valid, in, 1, filter output beat valid (counted only).
- o_busy, out, 1, frame in progress.
- o_done, out, 1, one-cycle pulse at frame completion.
- o_err, out, 1, sticky; credit counter saturated.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; all counters 0; o_err cleared.
- A beat transfers when o_data_valid && i_data_ready. A source beat is taken when i_src_valid && o_src_ready.
- Output register (one deep):
  - o_src_ready = (state is PRIME or LINE) && beats remaining to accept in the current segment > 0 && (!o_data_valid || i_data_ready).
  - A source beat taken in cycle n appears on o_data in cycle n+1.
  - o_data and o_data_valid hold stable while i_data_ready=0.
- Interrupt credits:
  - i_intr is rising-edge detected (registered previous value). Each edge adds 1 credit; a held level counts once.
  - Credits accrue from the cycle after start onward, including during PRIME.
  - An edge and a consumption in the same cycle leave the count unchanged.
  - The counter saturates at 2^CREDIT_W-1. An edge at saturation sets o_err.
- States:
  - IDLE: on i_start, clear counters and credits, set o_busy=1, go to PRIME.
  - PRIME: forward PRIME_LINES*IMG_WIDTH source beats. On the last output transfer, go to WAIT if lines_sent<IMG_HEIGHT, else PAD_WAIT (or DRAIN if PAD_LINES=0).
  - WAIT: if credits>0, consume one credit and go to LINE.
  - LINE: forward IMG_WIDTH source beats. On the last output transfer, lines_sent+1. Go to WAIT if lines_sent<IMG_HEIGHT, else PAD_WAIT/DRAIN as above.
  - PAD_WAIT: if credits>0, consume one credit and go to PAD.
  - PAD: drive PAD_VALUE for IMG_WIDTH transfers with o_src_ready=0. After PAD_LINES pad lines go to DRAIN, else return to PAD_WAIT.
  - DRAIN: wait until res_count == IMG_WIDTH*IMG_HEIGHT, then go to DONE.
  - DONE: o_done=1 for one cycle, o_busy=0, go to IDLE.
- Counting and widths:
  - res_count increments on i_res_valid while o_busy and saturates at IMG_WIDTH*IMG_HEIGHT; extra beats are ignored.
  - Counter widths are clog2 of their maximum plus 1.
  - The pixel counter resets at each line boundary.
- Reset mid-frame: aborts immediately; no partial state survives. The next i_start restarts from line 0.

Test Plan:
1. W=4, H=6, PRIME=4, PAD=2, source always valid with data 0..23, ready=1, start → pixels 0..15 on consecutive cycles starting one cycle after the first source acceptance, then idle. Each intr pulse yields 4 pixels (16..19, then 20..23). Two further intr pulses yield 4 zeros each. o_done pulses one cycle after the 24th i_res_valid.
2. Same config, i_data_ready toggling 1,0,1,0 → output sequence exactly 0..23 then 8 zeros, no duplicates or drops; o_data stable on every ready=0 cycle.
3. Three intr pulses during PRIME → both remaining lines and the first pad line sent back-to-back without stalling; the second pad line waits for a 4th intr.
4. i_intr held high for 10 cycles → exactly one credit (one line sent).
5. axi_reset_n low mid-LINE → o_data_valid, o_busy and o_src_ready fall to 0 asynchronously. A new start after release re-sends from source pixel 0 with a fresh prime.
6. CREDIT_W=4, 16 intr edges while in PRIME → credits=15 and o_err=1, held until reset.

Source files
------------

// File: rtl/line_stream_feeder.sv
// Feeds a line-buffered image filter: primes PRIME_LINES lines, then sends one line per
// interrupt credit, then interrupt-gated padding lines, and waits for every output beat.
module line_stream_feeder #(
    parameter int               IMG_WIDTH   = 512,
    parameter int               IMG_HEIGHT  = 512,
    parameter int               PIX_W       = 8,
    parameter int               PRIME_LINES = 4,
    parameter int               PAD_LINES   = 2,
    parameter logic [PIX_W-1:0] PAD_VALUE   = '0,
    parameter int               CREDIT_W    = 4
) (
    input  logic             axi_clk,
    input  logic             axi_reset_n,
    input  logic             i_start,
    input  logic             i_src_valid,
    input  logic [PIX_W-1:0] i_src_data,
    output logic             o_src_ready,
    output logic             o_data_valid,
    output logic [PIX_W-1:0] o_data,
    input  logic             i_data_ready,
    input  logic             i_intr,
    input  logic             i_res_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW    = $clog2(PRIME_LINES * IMG_WIDTH) + 1;
    localparam int PCW   = $clog2(IMG_WIDTH) + 1;
    localparam int LCW   = $clog2(IMG_HEIGHT) + 1;
    localparam int PDW   = $clog2(PAD_LINES + 1) + 1;
    localparam int RCW   = $clog2(TOTAL) + 1;

    localparam logic [AW-1:0]       PRIME_BEATS = AW'(PRIME_LINES * IMG_WIDTH);
    localparam logic [AW-1:0]       LINE_BEATS  = AW'(IMG_WIDTH);
    localparam logic [PCW-1:0]      PIX_LAST    = PCW'(IMG_WIDTH - 1);
    localparam logic [LCW-1:0]      PRIME_LAST  = LCW'(PRIME_LINES - 1);
    localparam logic [LCW-1:0]      HEIGHT      = LCW'(IMG_HEIGHT);
    localparam logic [PDW-1:0]      PAD_COUNT   = PDW'(PAD_LINES);
    localparam logic [RCW-1:0]      RES_TOTAL   = RCW'(TOTAL);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX  = {CREDIT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_WAIT, S_LINE, S_PAD_WAIT, S_PAD, S_DRAIN, S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [AW-1:0]        accept_left_reg;
    logic [PCW-1:0]       pix_reg;
    logic [LCW-1:0]       lines_sent_reg;
    logic [PDW-1:0]       pads_sent_reg;
    logic [RCW-1:0]       res_count_reg, res_count_next;
    logic [CREDIT_W-1:0]  credit_reg;
    logic                 intr_prev_reg;
    logic                 err_reg;
    logic                 valid_reg;
    logic [PIX_W-1:0]     data_reg;

    logic       slot_free, xfer, src_ready, src_take, pad_take, line_end, intr_edge;
    logic       start_frame, consume, load_line;
    logic [LCW-1:0] lines_after;
    state_t     data_exit;

    assign slot_free   = !valid_reg || i_data_ready;
    assign xfer        = valid_reg && i_data_ready;
    assign src_ready   = (state_reg == S_PRIME || state_reg == S_LINE)
                         && (accept_left_reg != '0) && slot_free;
    assign src_take    = i_src_valid && src_ready;
    assign pad_take    = (state_reg == S_PAD) && (accept_left_reg != '0) && slot_free;
    assign line_end    = xfer && (pix_reg == PIX_LAST);
    assign intr_edge   = i_intr && !intr_prev_reg && (state_reg != S_IDLE);
    assign lines_after = lines_sent_reg + LCW'(1);
    assign data_exit   = (lines_after < HEIGHT) ? S_WAIT
                         : ((PAD_LINES > 0) ? S_PAD_WAIT : S_DRAIN);

    assign o_src_ready  = src_ready;
    assign o_data_valid = valid_reg;
    assign o_data       = data_reg;
    assign o_busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign o_done       = (state_reg == S_DONE);
    assign o_err        = err_reg;

    // Result beats saturate at the frame size so stray extras cannot wrap the count.
    always_comb begin
        res_count_next = res_count_reg;
        if (i_res_valid && o_busy && res_count_reg != RES_TOTAL)
            res_count_next = res_count_reg + RCW'(1);
    end

    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        consume     = 1'b0;
        load_line   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    start_frame = 1'b1;
                    state_next  = S_PRIME;
                end
            end
            S_PRIME: begin
                if (line_end && lines_sent_reg == PRIME_LAST)
                    state_next = data_exit;
            end
            S_WAIT: begin
                if (credit_reg != '0) begin
                    consume    = 1'b1;
                    load_line  = 1'b1;
                    state_next = S_LINE;
                end
            end
            S_LINE: begin
                if (line_end)
                    state_next = data_exit;
            end
            S_PAD_WAIT: begin
                if (credit_reg != '0) begin
                    consume    = 1'b1;
                    load_line  = 1'b1;
                    state_next = S_PAD;
                end
            end
            S_PAD: begin
                if (line_end)
                    state_next = (pads_sent_reg + PDW'(1) == PAD_COUNT) ? S_DRAIN : S_PAD_WAIT;
            end
            S_DRAIN: begin
                if (res_count_next == RES_TOTAL)
                    state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_reg       <= S_IDLE;
            accept_left_reg <= '0;
            pix_reg         <= '0;
            lines_sent_reg  <= '0;
            pads_sent_reg   <= '0;
            res_count_reg   <= '0;
            credit_reg      <= '0;
            intr_prev_reg   <= 1'b0;
            err_reg         <= 1'b0;
            valid_reg       <= 1'b0;
            data_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            intr_prev_reg <= i_intr;

            if (start_frame) begin
                accept_left_reg <= PRIME_BEATS;
                pix_reg         <= '0;
                lines_sent_reg  <= '0;
                pads_sent_reg   <= '0;
                res_count_reg   <= '0;
                credit_reg      <= '0;
            end else begin
                if (load_line)
                    accept_left_reg <= LINE_BEATS;
                else if (src_take || pad_take)
                    accept_left_reg <= accept_left_reg - AW'(1);

                if (line_end)
                    pix_reg <= '0;
                else if (xfer)
                    pix_reg <= pix_reg + PCW'(1);

                if (line_end && (state_reg == S_PRIME || state_reg == S_LINE))
                    lines_sent_reg <= lines_after;
                if (line_end && state_reg == S_PAD)
                    pads_sent_reg <= pads_sent_reg + PDW'(1);

                res_count_reg <= res_count_next;

                // A simultaneous edge and consumption cancel out.
                if (intr_edge && !consume) begin
                    if (credit_reg == CREDIT_MAX)
                        err_reg <= 1'b1;
                    else
                        credit_reg <= credit_reg + CREDIT_W'(1);
                end else if (!intr_edge && consume) begin
                    credit_reg <= credit_reg - CREDIT_W'(1);
                end
            end

            if (src_take) begin
                data_reg  <= i_src_data;
                valid_reg <= 1'b1;
            end else if (pad_take) begin
                data_reg  <= PAD_VALUE;
                valid_reg <= 1'b1;
            end else if (xfer) begin
                valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_stream_feeder.sv
// Directed bench for line_stream_feeder with a 4x6 frame, 4 prime lines and 2 pad lines.
module tb_line_stream_feeder;

    logic       axi_clk = 1'b0;
    logic       axi_reset_n;
    logic       i_start, i_src_valid, i_data_ready, i_intr, i_res_valid;
    logic [7:0] i_src_data;
    logic       o_src_ready, o_data_valid, o_busy, o_done, o_err;
    logic [7:0] o_data;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         src_idx = 0;
    int         first_take = -1;
    logic [7:0] out_q[$];
    int         xc[$];

    line_stream_feeder #(
        .IMG_WIDTH(4), .IMG_HEIGHT(6), .PIX_W(8), .PRIME_LINES(4),
        .PAD_LINES(2), .PAD_VALUE(8'h00), .CREDIT_W(4)
    ) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .i_start(i_start),
        .i_src_valid(i_src_valid), .i_src_data(i_src_data), .o_src_ready(o_src_ready),
        .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(i_data_ready),
        .i_intr(i_intr), .i_res_valid(i_res_valid), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 axi_clk = ~axi_clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    // One clock: sample handshakes before the edge, update the source model after it.
    task automatic tick();
        logic       took, xf, stall;
        logic [7:0] xd;
        #1;
        took  = i_src_valid && o_src_ready;
        xf    = o_data_valid && i_data_ready;
        stall = o_data_valid && !i_data_ready;
        xd    = o_data;
        @(posedge axi_clk); #1;
        cyc++;
        if (took) begin
            if (first_take < 0) first_take = cyc - 1;
            src_idx++;
            i_src_data = 8'(src_idx);
        end
        if (xf) begin
            out_q.push_back(xd);
            xc.push_back(cyc - 1);
        end
        if (stall) begin
            chk("hold_valid", 32'(o_data_valid), 32'd1);
            chk("hold_data", 32'(o_data), 32'(xd));
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1; tick();
        i_intr = 1'b0; tick();
    endtask

    task automatic start_frame();
        i_start = 1'b1; tick();
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        axi_reset_n = 1'b0;
        i_start = 0; i_intr = 0; i_res_valid = 0; i_src_valid = 0; i_data_ready = 0;
        src_idx = 0; i_src_data = 8'd0; first_take = -1;
        out_q.delete(); xc.delete();
        @(posedge axi_clk); #1;
        axi_reset_n = 1'b1;
    endtask

    task automatic chk_lines(input string tag, input int from, input int upto);
        for (int k = from; k < upto; k++)
            chk(tag, 32'(out_q[k]), (k < 24) ? 32'(k) : 32'd0);
    endtask

    initial begin
        // Test 1: basic frame sequence with reset-state checks
        do_reset();
        chk("rst_valid", 32'(o_data_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_src_ready", 32'(o_src_ready), 0);
        i_src_valid = 1; i_data_ready = 1;
        start_frame();
        run(25);
        chk("t1_prime_count", 32'(out_q.size()), 16);
        chk_lines("t1_prime_data", 0, 16);
        chk("t1_first_lat", 32'(xc[0]), 32'(first_take + 1));
        chk("t1_consecutive", 32'(xc[15] - xc[0]), 15);
        chk("t1_busy", 32'(o_busy), 1);
        pulse_intr(); run(8);
        chk("t1_line5_count", 32'(out_q.size()), 20);
        pulse_intr(); run(8);
        chk("t1_line6_count", 32'(out_q.size()), 24);
        chk_lines("t1_lines_data", 16, 24);
        run(6);
        chk("t1_pad_gated", 32'(out_q.size()), 24);
        pulse_intr(); run(8);
        pulse_intr(); run(8);
        chk("t1_pad_count", 32'(out_q.size()), 32);
        chk_lines("t1_pad_data", 24, 32);
        chk("t1_drain_done", 32'(o_done), 0);
        i_res_valid = 1;
        run(23);
        chk("t1_done_early", 32'(o_done), 0);
        chk("t1_busy_drain", 32'(o_busy), 1);
        tick();
        chk("t1_done_pulse", 32'(o_done), 1);
        chk("t1_busy_at_done", 32'(o_busy), 0);
        i_res_valid = 0;
        tick();
        chk("t1_done_clear", 32'(o_done), 0);
        $display("test1 frame: transfers=%0d", out_q.size());

        // Test 2: downstream backpressure toggling every cycle
        do_reset();
        i_src_valid = 1;
        i_data_ready = 1;
        start_frame();
        for (int i = 0; i < 160; i++) begin
            i_data_ready = (i % 2 == 0);
            i_intr = (i == 30 || i == 60 || i == 90 || i == 120);
            tick();
        end
        i_intr = 0; i_data_ready = 1;
        chk("t2_count", 32'(out_q.size()), 32);
        chk_lines("t2_data", 0, 32);
        $display("test2 backpressure: transfers=%0d", out_q.size());

        // Test 3: credits banked during prime
        do_reset();
        i_src_valid = 1; i_data_ready = 1;
        start_frame();
        tick();
        pulse_intr(); pulse_intr(); pulse_intr();
        run(40);
        chk("t3_count", 32'(out_q.size()), 28);
        chk_lines("t3_data", 16, 28);
        run(20);
        chk("t3_pad2_gated", 32'(out_q.size()), 28);
        pulse_intr(); run(8);
        chk("t3_pad2_sent", 32'(out_q.size()), 32);
        $display("test3 banked credits: transfers=%0d", out_q.size());

        // Test 4: a held interrupt level is one credit
        do_reset();
        i_src_valid = 1; i_data_ready = 1;
        start_frame();
        run(20);
        i_intr = 1; run(10);
        i_intr = 0; run(10);
        chk("t4_one_line", 32'(out_q.size()), 20);
        chk("t4_last", 32'(out_q[19]), 19);
        pulse_intr(); run(8);
        chk("t4_next_line", 32'(out_q.size()), 24);
        $display("test4 held intr: transfers=%0d", out_q.size());

        // Test 5: asynchronous reset in the middle of a line
        do_reset();
        i_src_valid = 1; i_data_ready = 1;
        start_frame();
        run(20);
        pulse_intr();
        tick();
        chk("t5_pre_valid", 32'(o_data_valid), 1);
        chk("t5_pre_busy", 32'(o_busy), 1);
        #2;
        axi_reset_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(o_data_valid), 0);
        chk("t5_async_busy", 32'(o_busy), 0);
        chk("t5_async_src_ready", 32'(o_src_ready), 0);
        do_reset();
        i_src_valid = 1; i_data_ready = 1;
        start_frame();
        run(20);
        chk("t5_restart_count", 32'(out_q.size()), 16);
        chk("t5_restart_first", 32'(out_q[0]), 0);
        chk("t5_restart_last", 32'(out_q[15]), 15);
        $display("test5 reset restart: transfers=%0d", out_q.size());

        // Test 6: credit saturation sets the sticky error
        do_reset();
        i_src_valid = 0; i_data_ready = 1;
        start_frame();
        repeat (15) pulse_intr();
        chk("t6_err_before_sat", 32'(o_err), 0);
        pulse_intr();
        chk("t6_err_set", 32'(o_err), 1);
        i_src_valid = 1;
        run(70);
        chk("t6_frame_from_credits", 32'(out_q.size()), 32);
        chk("t6_err_sticky", 32'(o_err), 1);
        do_reset();
        chk("t6_err_reset", 32'(o_err), 0);
        $display("test6 saturation: transfers=%0d", out_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
